// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the iterative multiply/divide unit.
//                Op encoding, FSM state type and a small decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mdu_pkg;

    // Operation encoding presented on the op port
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10,
        DONE = 2'b11
    } state_t;

    // Bit 0 of the op code distinguishes the unsigned variants
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_seq_if
//  Description : Request / result bundle between the execute stage and the
//                multiply/divide unit.
//  Ports       : start, op, a, b         operation request
//                hi_we, lo_we, wdata     MTHI / MTLO writes
//                busy, done, hi, lo      status and architectural HI/LO
//  Modports    : master (execute stage), slave (mdu_seq)
//  Revision    : 1.0  initial release
// ============================================================================
interface mdu_seq_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [N-1:0] wdata;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface : mdu_seq_if
`default_nettype wire

// File: rtl/mdu_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_addsub
//  Description : N-bit adder/subtractor with carry-out. When sub_i is set the
//                y operand is inverted and the carry-in forced to one, so
//                cout_o = 1 means "no borrow" for x_i - y_i.
//  Ports       : x_i, y_i   operands
//                sub_i      0 = add, 1 = subtract
//                sum_o      N-bit result
//                cout_o     carry out (inverted borrow when subtracting)
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_addsub #(
    parameter int N = 32
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N-1:0] w_y;

    assign w_y             = sub_i ? ~y_i : y_i;
    assign {cout_o, sum_o} = {1'b0, x_i} + {1'b0, w_y} + {{N{1'b0}}, sub_i};

endmodule : mdu_addsub
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_seq
//  Description : Iterative multiply/divide unit. MULT/MULTU use shift-add,
//                DIV/DIVU use restoring division, one bit per cycle on
//                unsigned magnitudes; the sign fix-up is applied in a final
//                SIGN cycle that also writes HI/LO.
//  Ports       : clk        rising-edge clock
//                rst_n      synchronous reset, active low
//                bus        mdu_seq_if.slave (request, MTHI/MTLO, status, HI/LO)
//  Build macro : MDU_DIV_EN  defined   -> full divide datapath
//                            undefined -> DIV/DIVU complete immediately and
//                                         leave HI/LO untouched
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    mdu_seq_if.slave bus
);

    localparam int            CW         = $clog2(N);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(N - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [2*N-1:0]  acc_q,     acc_d;      // product, or remainder:quotient
    logic [N-1:0]    mcand_q,   mcand_d;    // |multiplicand| or |divisor|
    logic            neg_res_q, neg_res_d;  // product / quotient is negative
    logic [N-1:0]    hi_q,      hi_d;
    logic [N-1:0]    lo_q,      lo_d;
`ifdef MDU_DIV_EN
    logic            is_div_q,  is_div_d;
    logic            neg_rem_q, neg_rem_d;  // remainder follows dividend sign
    logic            dvz_q,     dvz_d;      // divide by zero
    logic [N-1:0]    a_raw_q,   a_raw_d;    // dividend as issued, for /0
`endif

    // ------------------------------------------------------------------
    // Operand conditioning: magnitudes for signed ops, raw for unsigned
    // ------------------------------------------------------------------
    logic            w_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [N-1:0]    w_abs_a;
    logic [N-1:0]    w_abs_b;

    assign w_signed = op_is_signed(bus.op);
    assign w_neg_a  = w_signed & bus.a[N-1];
    assign w_neg_b  = w_signed & bus.b[N-1];
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    assign w_abs_a  = w_neg_a ? -bus.a : bus.a;
    assign w_abs_b  = w_neg_b ? -bus.b : bus.b;

    // ------------------------------------------------------------------
    // Shared adder: upper half + multiplicand, or shifted remainder - divisor
    // ------------------------------------------------------------------
    logic [N-1:0]    w_add_x;
    logic            w_add_sub;
    logic [N-1:0]    w_add_sum;
    logic            w_add_cout;

`ifdef MDU_DIV_EN
    // For division the adder sees the remainder after the left shift,
    // i.e. acc bits [2N-2:N-1].
    assign w_add_x   = is_div_q ? acc_q[2*N-2:N-1] : acc_q[2*N-1:N];
    assign w_add_sub = is_div_q;
`else
    assign w_add_x   = acc_q[2*N-1:N];
    assign w_add_sub = 1'b0;
`endif

    mdu_addsub #(
        .N (N)
    ) u_addsub (
        .x_i    (w_add_x),
        .y_i    (mcand_q),
        .sub_i  (w_add_sub),
        .sum_o  (w_add_sum),
        .cout_o (w_add_cout)
    );

    // ------------------------------------------------------------------
    // Per-iteration accumulator updates
    // ------------------------------------------------------------------
    logic [2*N-1:0]  w_mul_step;
    logic [2*N-1:0]  w_prod;

    // Carry from the add becomes the new MSB after the right shift.
    assign w_mul_step = acc_q[0] ? {w_add_cout, w_add_sum, acc_q[N-1:1]}
                                 : {1'b0, acc_q[2*N-1:1]};
    assign w_prod     = neg_res_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
    logic [2*N-1:0]  w_div_step;
    logic            w_no_borrow;
    logic [N-1:0]    w_quo;
    logic [N-1:0]    w_rem;

    // The bit shifted out of the remainder counts as an extra MSB: if it is
    // set, the shifted remainder exceeds any N-bit divisor.
    assign w_no_borrow = w_add_cout | acc_q[2*N-1];
    assign w_div_step  = w_no_borrow ? {w_add_sum, acc_q[N-2:0], 1'b1}
                                     : {acc_q[2*N-2:0], 1'b0};
    assign w_quo       = acc_q[N-1:0];
    assign w_rem       = acc_q[2*N-1:N];
`endif

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef MDU_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        dvz_d     = dvz_q;
        a_raw_d   = a_raw_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                // MTHI/MTLO are honoured even on the edge that starts an op.
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                state_d = IDLE;

                if (bus.start) begin
                    if (bus.op[1]) begin
`ifdef MDU_DIV_EN
                        state_d   = CALC;
                        cnt_d     = C_CNT_LAST;
                        is_div_d  = 1'b1;
                        neg_res_d = w_neg_a ^ w_neg_b;
                        neg_rem_d = w_neg_a;
                        dvz_d     = (bus.b == '0);
                        a_raw_d   = bus.a;
                        acc_d     = {{N{1'b0}}, w_abs_a};
                        mcand_d   = w_abs_b;
`else
                        // No divider: acknowledge at once, HI/LO untouched.
                        state_d   = DONE;
`endif
                    end else begin
                        state_d   = CALC;
                        cnt_d     = C_CNT_LAST;
                        neg_res_d = w_neg_a ^ w_neg_b;
                        acc_d     = {{N{1'b0}}, w_abs_b};
                        mcand_d   = w_abs_a;
`ifdef MDU_DIV_EN
                        is_div_d  = 1'b0;
`endif
                    end
                end
            end

            CALC: begin
`ifdef MDU_DIV_EN
                acc_d = is_div_q ? w_div_step : w_mul_step;
`else
                acc_d = w_mul_step;
`endif
                if (cnt_q == '0) begin
                    state_d = SIGN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            SIGN: begin
                state_d = DONE;
`ifdef MDU_DIV_EN
                if (is_div_q) begin
                    if (dvz_q) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = neg_res_q ? -w_quo : w_quo;
                        hi_d = neg_rem_q ? -w_rem : w_rem;
                    end
                end else begin
                    hi_d = w_prod[2*N-1:N];
                    lo_d = w_prod[N-1:0];
                end
`else
                hi_d = w_prod[2*N-1:N];
                lo_d = w_prod[N-1:0];
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef MDU_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            dvz_q     <= 1'b0;
            a_raw_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef MDU_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            dvz_q     <= dvz_d;
            a_raw_q   <= a_raw_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy = (state_q == CALC) || (state_q == SIGN);
    assign bus.done = (state_q == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule : mdu_seq
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_seq
//  Description : Directed self-checking bench for mdu_seq (N = 32). Divide
//                vectors apply when MDU_DIV_EN is defined, otherwise the
//                immediate-completion behaviour of DIV/DIVU is exercised.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_seq;
    import mdu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mdu_seq_if #(.N(32)) bus ();

    mdu_seq #(
        .N (32)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait for done; cyc = cycles from accepted start to
    // done (-1 on timeout); b1/d1 = busy/done right after the start edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cyc,
                          output int bcnt, output logic b1, output logic d1);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        cyc  = -1;
        bcnt = 0;
        b1   = 1'b0;
        d1   = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 1) begin
                bus.start = 1'b0;
                b1 = bus.busy;
                d1 = bus.done;
            end
            if (bus.busy) bcnt++;
            if (bus.done) begin
                cyc = k;
                break;
            end
        end
    endtask

    // Continue an op already in flight; k0 = cycles elapsed so far
    task automatic wait_done(input int k0, output int cyc);
        cyc = -1;
        for (int k = k0 + 1; k <= 100; k++) begin
            tick();
            if (bus.done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_checks++;
        if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", bus.hi); end
        n_checks++;
        if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 00000000", bus.lo); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        vec_t v [6];
        int   cyc, bcnt;
        logic b1, d1;
        v[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        v[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        v[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        v[3] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        v[4] = '{OP_MULTU, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E};
        v[5] = '{OP_MULT,  32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, cyc, bcnt, b1, d1);
            n_checks++;
            if (cyc !== 34) begin n_fail++; $display("FAIL mult%0d_latency: got %0d expected 34", i, cyc); end
            n_checks++;
            if (bcnt !== 33) begin n_fail++; $display("FAIL mult%0d_busy_cycles: got %0d expected 33", i, bcnt); end
            n_checks++;
            if (bus.hi !== v[i].hi) begin n_fail++; $display("FAIL mult%0d_hi: got %h expected %h", i, bus.hi, v[i].hi); end
            n_checks++;
            if (bus.lo !== v[i].lo) begin n_fail++; $display("FAIL mult%0d_lo: got %h expected %h", i, bus.lo, v[i].lo); end
            tick();
            n_checks++;
            if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mult%0d_done_pulse: got %b expected 0", i, bus.done); end
        end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        vec_t v [6];
        int   cyc, bcnt;
        logic b1, d1;
        v[0] = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        v[1] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        v[2] = '{OP_DIVU, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        v[3] = '{OP_DIVU, 32'h00000064, 32'h00000003, 32'h00000001, 32'h00000021};
        v[4] = '{OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        v[5] = '{OP_DIVU, 32'hFFFFFFFF, 32'hC0000000, 32'h3FFFFFFF, 32'h00000001};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, cyc, bcnt, b1, d1);
            n_checks++;
            if (cyc !== 34) begin n_fail++; $display("FAIL div%0d_latency: got %0d expected 34", i, cyc); end
            n_checks++;
            if (bus.hi !== v[i].hi) begin n_fail++; $display("FAIL div%0d_hi: got %h expected %h", i, bus.hi, v[i].hi); end
            n_checks++;
            if (bus.lo !== v[i].lo) begin n_fail++; $display("FAIL div%0d_lo: got %h expected %h", i, bus.lo, v[i].lo); end
            tick();
        end
    endtask
`else
    task automatic test_div_disabled();
        int   cyc, bcnt;
        logic b1, d1;
        bus.hi_we = 1'b1; bus.wdata = 32'h00001111; tick(); bus.hi_we = 1'b0;
        bus.lo_we = 1'b1; bus.wdata = 32'h00002222; tick(); bus.lo_we = 1'b0;
        run_op(OP_DIVU, 32'd100, 32'd3, cyc, bcnt, b1, d1);
        n_checks++;
        if (cyc !== 1) begin n_fail++; $display("FAIL nodiv_latency: got %0d expected 1", cyc); end
        n_checks++;
        if (bcnt !== 0) begin n_fail++; $display("FAIL nodiv_busy: got %0d expected 0", bcnt); end
        n_checks++;
        if (bus.hi !== 32'h00001111) begin n_fail++; $display("FAIL nodiv_hi: got %h expected 00001111", bus.hi); end
        n_checks++;
        if (bus.lo !== 32'h00002222) begin n_fail++; $display("FAIL nodiv_lo: got %h expected 00002222", bus.lo); end
        tick();
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL nodiv_done_pulse: got %b expected 0", bus.done); end
    endtask
`endif

    task automatic test_reset_midop();
        int   cyc, bcnt;
        logic b1, d1;
        // Leave a nonzero result behind so the reset clearing is visible
        run_op(OP_MULTU, 32'd7, 32'd9, cyc, bcnt, b1, d1);
        tick();
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd5; bus.b = 32'd6;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();          // now in cycle 10
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
        n_checks++;
        if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL midrst_hi: got %h expected 00000000", bus.hi); end
        n_checks++;
        if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL midrst_lo: got %h expected 00000000", bus.lo); end
        rst_n = 1'b1;
        run_op(OP_MULTU, 32'd2, 32'd3, cyc, bcnt, b1, d1);
        n_checks++;
        if (cyc !== 34) begin n_fail++; $display("FAIL postrst_latency: got %0d expected 34", cyc); end
        n_checks++;
        if (bus.lo !== 32'd6) begin n_fail++; $display("FAIL postrst_lo: got %h expected 00000006", bus.lo); end
        tick();
    endtask

    task automatic test_busy_ignore();
        int cyc;
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd5; bus.b = 32'd6;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();          // cycle 5
        bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd100; bus.b = 32'd100;
        bus.lo_we = 1'b1; bus.wdata = 32'h00001234;
        tick();                     // cycle 6
        bus.start = 1'b0; bus.lo_we = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: got %b expected 1", bus.busy); end
        n_checks++;
        if (bus.lo !== 32'd6) begin n_fail++; $display("FAIL ignore_mtlo: got %h expected 00000006", bus.lo); end
        wait_done(6, cyc);
        n_checks++;
        if (cyc !== 34) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 34", cyc); end
        n_checks++;
        if (bus.lo !== 32'd30) begin n_fail++; $display("FAIL ignore_lo: got %h expected 0000001e", bus.lo); end
        // MTLO in DONE takes effect
        bus.lo_we = 1'b1; bus.wdata = 32'h00001234;
        tick();
        bus.lo_we = 1'b0;
        n_checks++;
        if (bus.lo !== 32'h00001234) begin n_fail++; $display("FAIL mtlo_done: got %h expected 00001234", bus.lo); end
        n_checks++;
        if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL mtlo_done_hi: got %h expected 00000000", bus.hi); end
    endtask

    task automatic test_mthi_with_start();
        int cyc;
        bus.hi_we = 1'b1; bus.wdata = 32'h0000ABCD;
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd2; bus.b = 32'd2;
        tick();
        bus.hi_we = 1'b0; bus.start = 1'b0;
        n_checks++;
        if (bus.hi !== 32'h0000ABCD) begin n_fail++; $display("FAIL mthi_start_hi: got %h expected 0000abcd", bus.hi); end
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mthi_start_busy: got %b expected 1", bus.busy); end
        wait_done(1, cyc);
        n_checks++;
        if (cyc !== 34) begin n_fail++; $display("FAIL mthi_start_latency: got %0d expected 34", cyc); end
        n_checks++;
        if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL mthi_start_res_hi: got %h expected 00000000", bus.hi); end
        n_checks++;
        if (bus.lo !== 32'd4) begin n_fail++; $display("FAIL mthi_start_res_lo: got %h expected 00000004", bus.lo); end
        tick();
    endtask

    task automatic test_back_to_back();
        int   cyc, bcnt;
        logic b1, d1;
        run_op(OP_MULTU, 32'd7, 32'd8, cyc, bcnt, b1, d1);
        n_checks++;
        if (bus.lo !== 32'd56) begin n_fail++; $display("FAIL b2b_first_lo: got %h expected 00000038", bus.lo); end
        // Still in DONE: issue the next op immediately
        run_op(OP_MULTU, 32'd9, 32'd9, cyc, bcnt, b1, d1);
        n_checks++;
        if (b1 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_rise: got %b expected 1", b1); end
        n_checks++;
        if (d1 !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b expected 0", d1); end
        n_checks++;
        if (cyc !== 34) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 34", cyc); end
        n_checks++;
        if (bus.lo !== 32'd81) begin n_fail++; $display("FAIL b2b_second_lo: got %h expected 00000051", bus.lo); end
        tick();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        test_reset();
        test_mult();
`ifdef MDU_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_reset_midop();
        test_busy_ignore();
        test_mthi_with_start();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_mdu_seq
`default_nettype wire

// File: doc/mdu_seq.md
# mdu_seq

Iterative multiply/divide unit for the execute stage. Runs MULT, MULTU, DIV and DIVU one bit per cycle and holds the result in the architectural HI/LO registers. Each iteration uses one n-bit add/subtract with carry-out: the shift-add step for multiplication and the trial subtraction for division. It sits beside the single-cycle arithmetic path, takes the same register operands, and returns HI/LO to the writeback mux for MFHI/MFLO.

## Interface
- n, 32, operand/result width; n ≥ 4
- clk  in  1  clock; every register updates on the rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  operation request
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  n  multiplicand / dividend
- b  in  n  multiplier / divisor
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  n  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hi  out  n  HI register
- lo  out  n  LO register

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE or DONE with start=1 → CALC. Latch op, and latch |a| and |b| for signed ops or raw a and b for unsigned ops. Latch sign flags. Set the counter to n-1.
- IDLE or DONE with start=0 → IDLE.
- CALC: one iteration per cycle; counter decrements; at counter=0 → SIGN.
  - Multiply: if the accumulator LSB is 1, add the multiplicand to the upper half (carry kept); then shift the 2n-bit accumulator right by 1.
  - Divide (restoring): shift the remainder:quotient pair left; trial-subtract the divisor from the remainder; if there is no borrow, keep the difference and set the quotient LSB.
- SIGN → DONE unconditionally; HI/LO are written on this edge.
  - MULT: negate the 2n-bit product when a[n-1]^b[n-1].
  - DIV: negate the quotient when signs differ; the remainder takes the dividend's sign.
  - Divide by zero (b==0, signed or unsigned): lo = all ones, hi = a as issued.
  - DIV of most-negative by -1: lo = 0x80000000, hi = 0 (natural wrap, no trap).
- MTHI/MTLO: hi_we/lo_we write wdata in IDLE or DONE only. They are ignored in CALC and SIGN. When they coincide with start, the write occurs and the operation starts.
- start in CALC or SIGN is ignored; no queuing.
- Overflow is never signalled.

## Timing
- Reset (rst_n=0 at an edge), including mid-operation: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. The in-flight result is discarded.
- Start accepted at edge E0:
  - CALC occupies cycles 1..n.
  - SIGN is cycle n+1.
  - DONE is cycle n+2: done=1 and hi/lo hold the new result.
  - n=32 → 34 cycles from accepted start to done.
- busy=1 exactly in CALC and SIGN; busy=0 in IDLE and DONE.
- done=1 exactly in DONE, for a single cycle unless back-to-back.
- Back-to-back: start during DONE enters CALC on the next edge. done drops and busy rises on that same edge.
- hi/lo are stable except at the SIGN→DONE edge and at accepted MTHI/MTLO edges.

## Configuration
- MDU_DIV_EN defined: full divide support as above.
- MDU_DIV_EN undefined:
  - The divide datapath and trial subtraction are removed.
  - DIV/DIVU are accepted but go directly IDLE/DONE → DONE on the start edge: done=1 the next cycle, busy never asserts, and hi/lo are unchanged.
  - Multiply behaviour is identical in both builds.

## Structure
- Package mdu_pkg: op encoding localparams (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state enum (IDLE, CALC, SIGN, DONE).
- Sub-module mdu_addsub: n-bit adder/subtractor.
  - Inputs x, y, sub.
  - Outputs sum and cout; y is inverted and the carry-in set when sub=1.
  - One instance is shared between the multiply add and the divide trial subtraction.
- Top level holds the FSM, counter, accumulator, sign flags and the HI/LO registers.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after start; busy high for 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=0x00000064. Without MDU_DIV_EN: DIVU 100/3 → done the next cycle, hi/lo unchanged.
- Start MULTU 5×6, assert rst_n=0 in cycle 10 → busy=0, done=0, hi=lo=0; a new MULTU 2×3 then completes with lo=6.
- Start while busy (new operands) is ignored and the first result is kept. MTLO wdata=0x1234 while busy is ignored; MTLO in DONE → lo=0x1234 next cycle. Back-to-back start in DONE yields the second result 34 cycles later.
